stack16_addr_unit: RTL and testbench
====================================

Name: stack16_addr_unit

Overview:
- Address-generation stage directly downstream of the control FSM.
- Holds the program counter (PC), data-stack pointer (DSP) and return-stack pointer (RSP).
- Applies the FSM's clock-enable, load and direction strobes to those registers, and muxes the 16-bit memory address per addr_sel.
- Detects stack overflow/underflow against fixed bounds and reports sticky fault flags. The FSM or interrupt logic consumes these flags.

Parameters:
RESET_PC, 16'h0000, PC value after reset
DSP_BASE, 16'h0100, DSP value after reset; lowest legal DSP (empty data stack)
DSP_LIMIT, 16'h01FF, highest legal DSP (full data stack)
RSP_BASE, 16'h0200, RSP value after reset; lowest legal RSP
RSP_LIMIT, 16'h02FF, highest legal RSP

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
pc_clken  in  1  PC update enable
pc_load  in  1  when pc_clken=1: 1=load load_value, 0=increment
load_value  in  16  PC load source (datapath top/ALU)
dsp_clken  in  1  DSP update enable
dsp_up  in  1  1=DSP+1 (push), 0=DSP-1 (pop)
rsp_clken  in  1  RSP update enable
rsp_up  in  1  1=RSP+1, 0=RSP-1
addr_sel  in  2  0=PC, 1=DSP, 2=RSP, 3=alu_addr
alu_addr  in  16  ALU-computed address
fault_clr  in  1  clears all sticky fault flags
addr  out  16  memory address
pc  out  16  current PC
dsp  out  16  current DSP
rsp  out  16  current RSP
dsp_ovf  out  1  sticky: push attempted at DSP_LIMIT
dsp_unf  out  1  sticky: pop attempted at DSP_BASE
rsp_ovf  out  1  sticky: push attempted at RSP_LIMIT
rsp_unf  out  1  sticky: pop attempted at RSP_BASE
stack_fault  out  1  OR of the four sticky flags

Behaviour:
- Reset (synchronous, dominates every other input in the same cycle): pc=RESET_PC, dsp=DSP_BASE, rsp=RSP_BASE, all four flags=0, stack_fault=0. Reset asserted mid-sequence discards all pending strobes.
- addr is purely combinational from the current register values and alu_addr, with zero latency. It reflects pre-update values in the cycle a strobe is asserted. The FSM orders its push/pop sequencing around this.
- PC:
  - pc_clken=0: hold; pc_load is ignored.
  - pc_clken=1, pc_load=1: pc<=load_value.
  - pc_clken=1, pc_load=0: pc<=pc+1, mod 2^16 (FFFF->0000, no flag).
- DSP (RSP identical with its own bounds and flags):
  - dsp_clken=0: hold.
  - Up with dsp!=DSP_LIMIT: dsp+1.
  - Up with dsp==DSP_LIMIT: dsp holds, dsp_ovf<=1.
  - Down with dsp!=DSP_BASE: dsp-1.
  - Down with dsp==DSP_BASE: dsp holds, dsp_unf<=1.
  - Pointers never leave [BASE, LIMIT], so no 16-bit wrap is possible.
- PC, DSP and RSP update independently. Any combination of enables in one cycle is legal and all apply in that cycle.
- Flags:
  - Set on the edge where the faulting strobe is sampled.
  - Remain set until fault_clr or reset.
  - fault_clr=1 in the same cycle as a new fault: the new fault's flag ends at 1 and the other flags clear.
  - stack_fault is combinational OR of the registered flags, so it is high the cycle after the fault edge.
- No internal FSM; the behaviour is a register bank with guarded arithmetic. Flags are 2-state registers (clear/set).

Test Plan:
- Reset, then a 3-cycle idle -> pc=0000, dsp=0100, rsp=0200, addr=0000 (addr_sel=0), all flags 0.
- pc_clken=1, pc_load=0 for 3 cycles, then pc_clken=1, pc_load=1, load_value=FFFF, then 1 increment -> pc 0001, 0002, 0003, FFFF, 0000; no flag.
- Push DSP 255 times -> dsp=01FF, dsp_ovf=0. 256th push -> dsp stays 01FF, dsp_ovf=1, stack_fault=1. fault_clr -> flags 0.
- From reset, rsp pop -> rsp stays 0200, rsp_unf=1. Next cycle: rsp push with fault_clr=1 -> rsp=0201, rsp_unf=0.
- Same cycle: pc increment, dsp push, rsp pop (rsp=0205) with addr_sel sweeping 0..3 (alu_addr=1234) -> addr equals the pre-edge pc/dsp/rsp/1234 respectively. After the edge, all three registers have updated.
- dsp=01FF, then one cycle with a dsp push plus fault_clr=1 while rsp_unf=1 -> dsp_ovf=1, rsp_unf=0. Reset asserted alongside pc_load=1, load_value=ABCD -> pc=RESET_PC, all flags 0.

Source files
------------

// File: rtl/stack16_addr_unit.sv
// Address-generation stage: PC, data-stack and return-stack pointers with
// bounds-guarded push/pop, sticky overflow/underflow flags and address mux.

module stack16_sp #(
    parameter logic [15:0] BASE  = 16'h0100,
    parameter logic [15:0] LIMIT = 16'h01FF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clken,
    input  logic        up,
    input  logic        fault_clr,
    output logic [15:0] ptr,
    output logic        ovf,
    output logic        unf
);
    logic [15:0] ptr_q, ptr_d;
    logic        ovf_q, ovf_d, unf_q, unf_d;
    logic        ovf_set, unf_set;

    always_comb begin
        ptr_d   = ptr_q;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (clken) begin
            if (up) begin
                if (ptr_q == LIMIT) ovf_set = 1'b1;
                else                ptr_d   = ptr_q + 16'd1;
            end else begin
                if (ptr_q == BASE)  unf_set = 1'b1;
                else                ptr_d   = ptr_q - 16'd1;
            end
        end
        // A fault in the same cycle as fault_clr survives the clear.
        ovf_d = (ovf_q & ~fault_clr) | ovf_set;
        unf_d = (unf_q & ~fault_clr) | unf_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= BASE;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign ptr = ptr_q;
    assign ovf = ovf_q;
    assign unf = unf_q;
endmodule

module stack16_addr_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] DSP_BASE  = 16'h0100,
    parameter logic [15:0] DSP_LIMIT = 16'h01FF,
    parameter logic [15:0] RSP_BASE  = 16'h0200,
    parameter logic [15:0] RSP_LIMIT = 16'h02FF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_clken,
    input  logic        pc_load,
    input  logic [15:0] load_value,
    input  logic        dsp_clken,
    input  logic        dsp_up,
    input  logic        rsp_clken,
    input  logic        rsp_up,
    input  logic [1:0]  addr_sel,
    input  logic [15:0] alu_addr,
    input  logic        fault_clr,
    output logic [15:0] addr,
    output logic [15:0] pc,
    output logic [15:0] dsp,
    output logic [15:0] rsp,
    output logic        dsp_ovf,
    output logic        dsp_unf,
    output logic        rsp_ovf,
    output logic        rsp_unf,
    output logic        stack_fault
);
    logic [15:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (pc_clken) pc_d = pc_load ? load_value : pc_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) pc_q <= RESET_PC;
        else       pc_q <= pc_d;
    end

    stack16_sp #(.BASE(DSP_BASE), .LIMIT(DSP_LIMIT)) u_dsp (
        .clk(clk), .reset(reset), .clken(dsp_clken), .up(dsp_up),
        .fault_clr(fault_clr), .ptr(dsp), .ovf(dsp_ovf), .unf(dsp_unf)
    );

    stack16_sp #(.BASE(RSP_BASE), .LIMIT(RSP_LIMIT)) u_rsp (
        .clk(clk), .reset(reset), .clken(rsp_clken), .up(rsp_up),
        .fault_clr(fault_clr), .ptr(rsp), .ovf(rsp_ovf), .unf(rsp_unf)
    );

    // Address reflects pre-update register values in the strobe cycle.
    always_comb begin
        case (addr_sel)
            2'd0:    addr = pc_q;
            2'd1:    addr = dsp;
            2'd2:    addr = rsp;
            default: addr = alu_addr;
        endcase
    end

    assign pc          = pc_q;
    assign stack_fault = dsp_ovf | dsp_unf | rsp_ovf | rsp_unf;
endmodule

// File: tb/tb_stack16_addr_unit.sv
// Directed bench for stack16_addr_unit: per-cycle check against a behavioural
// model plus hand-computed literal expectations.

module tb_stack16_addr_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pc_clken = 1'b0, pc_load = 1'b0;
    logic [15:0] load_value = 16'h0000;
    logic        dsp_clken = 1'b0, dsp_up = 1'b0;
    logic        rsp_clken = 1'b0, rsp_up = 1'b0;
    logic [1:0]  addr_sel = 2'd0;
    logic [15:0] alu_addr = 16'h0000;
    logic        fault_clr = 1'b0;
    logic [15:0] addr, pc, dsp, rsp;
    logic        dsp_ovf, dsp_unf, rsp_ovf, rsp_unf, stack_fault;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    stack16_addr_unit dut (
        .clk(clk), .reset(reset), .pc_clken(pc_clken), .pc_load(pc_load),
        .load_value(load_value), .dsp_clken(dsp_clken), .dsp_up(dsp_up),
        .rsp_clken(rsp_clken), .rsp_up(rsp_up), .addr_sel(addr_sel),
        .alu_addr(alu_addr), .fault_clr(fault_clr), .addr(addr), .pc(pc),
        .dsp(dsp), .rsp(rsp), .dsp_ovf(dsp_ovf), .dsp_unf(dsp_unf),
        .rsp_ovf(rsp_ovf), .rsp_unf(rsp_unf), .stack_fault(stack_fault)
    );

    always #5 clk = ~clk;

    // Behavioural model: registers as plain numbers, pointers clamp at bounds.
    int m_pc = 0, m_dsp = 'h100, m_rsp = 'h200;
    bit m_dovf = 0, m_dunf = 0, m_rovf = 0, m_runf = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_pc <= 0; m_dsp <= 'h100; m_rsp <= 'h200;
            m_dovf <= 0; m_dunf <= 0; m_rovf <= 0; m_runf <= 0;
        end else begin
            if (pc_clken) m_pc <= pc_load ? int'(load_value) : (m_pc + 1) % 65536;
            if (dsp_clken && dsp_up && m_dsp < 'h1FF)    m_dsp <= m_dsp + 1;
            if (dsp_clken && !dsp_up && m_dsp > 'h100)   m_dsp <= m_dsp - 1;
            if (rsp_clken && rsp_up && m_rsp < 'h2FF)    m_rsp <= m_rsp + 1;
            if (rsp_clken && !rsp_up && m_rsp > 'h200)   m_rsp <= m_rsp - 1;
            m_dovf <= (m_dovf && !fault_clr) || (dsp_clken && dsp_up && m_dsp == 'h1FF);
            m_dunf <= (m_dunf && !fault_clr) || (dsp_clken && !dsp_up && m_dsp == 'h100);
            m_rovf <= (m_rovf && !fault_clr) || (rsp_clken && rsp_up && m_rsp == 'h2FF);
            m_runf <= (m_runf && !fault_clr) || (rsp_clken && !rsp_up && m_rsp == 'h200);
        end
    end

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        int ea;
        case (addr_sel)
            2'd0: ea = m_pc;
            2'd1: ea = m_dsp;
            2'd2: ea = m_rsp;
            default: ea = int'(alu_addr);
        endcase
        chk("m_addr", addr, 16'(ea));
        chk("m_pc", pc, 16'(m_pc));
        chk("m_dsp", dsp, 16'(m_dsp));
        chk("m_rsp", rsp, 16'(m_rsp));
        chk("m_flags", {12'h0, dsp_ovf, dsp_unf, rsp_ovf, rsp_unf},
            {12'h0, m_dovf, m_dunf, m_rovf, m_runf});
        chk("m_stack_fault", {15'h0, stack_fault}, {15'h0, m_dovf | m_dunf | m_rovf | m_runf});
    endtask

    // Inputs are set just after a rising edge; the check runs on the falling edge.
    task automatic cyc();
        @(negedge clk);
        if (chk_on) cmp_model();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; pc_clken = 0; pc_load = 0; dsp_clken = 0; rsp_clken = 0;
        fault_clr = 0; addr_sel = 2'd0;
    endtask

    task automatic flags(string nm, logic [3:0] exp);
        chk(nm, {12'h0, dsp_ovf, dsp_unf, rsp_ovf, rsp_unf}, {12'h0, exp});
    endtask

    initial begin
        reset = 1;
        cyc(); cyc();
        chk_on = 1'b1;
        idle();
        repeat (3) cyc();
        chk("rst_pc", pc, 16'h0000);
        chk("rst_dsp", dsp, 16'h0100);
        chk("rst_rsp", rsp, 16'h0200);
        chk("rst_addr", addr, 16'h0000);
        flags("rst_flags", 4'b0000);

        // PC increment, load and wrap
        pc_clken = 1; pc_load = 0;
        cyc(); chk("pc_inc1", pc, 16'h0001);
        cyc(); chk("pc_inc2", pc, 16'h0002);
        cyc(); chk("pc_inc3", pc, 16'h0003);
        pc_load = 1; load_value = 16'hFFFF;
        cyc(); chk("pc_load", pc, 16'hFFFF);
        pc_load = 0;
        cyc(); chk("pc_wrap", pc, 16'h0000);
        flags("pc_noflag", 4'b0000);
        idle();

        // DSP fill to limit, then overflow
        dsp_clken = 1; dsp_up = 1;
        repeat (255) cyc();
        chk("dsp_full", dsp, 16'h01FF);
        flags("dsp_full_flags", 4'b0000);
        cyc();
        chk("dsp_ovf_hold", dsp, 16'h01FF);
        flags("dsp_ovf", 4'b1000);
        chk("dsp_ovf_sf", {15'h0, stack_fault}, 16'h0001);
        idle(); cyc();
        flags("dsp_ovf_sticky", 4'b1000);
        fault_clr = 1; cyc(); idle();
        flags("fault_clr", 4'b0000);

        // RSP underflow, then push with clear
        reset = 1; cyc(); idle();
        rsp_clken = 1; rsp_up = 0;
        cyc();
        chk("rsp_unf_hold", rsp, 16'h0200);
        flags("rsp_unf", 4'b0001);
        rsp_up = 1; fault_clr = 1;
        cyc(); fault_clr = 0;
        chk("rsp_push_clr", rsp, 16'h0201);
        flags("rsp_unf_clr", 4'b0000);
        repeat (4) cyc();
        chk("rsp_0205", rsp, 16'h0205);
        idle();

        // Concurrent updates with addr_sel sweep: addr shows pre-edge values
        pc_clken = 1; pc_load = 0; dsp_clken = 1; dsp_up = 1;
        rsp_clken = 1; rsp_up = 0; alu_addr = 16'h1234;
        addr_sel = 2'd0; #1 chk("sweep_pc", addr, 16'h0000); cyc();
        addr_sel = 2'd1; #1 chk("sweep_dsp", addr, 16'h0101); cyc();
        addr_sel = 2'd2; #1 chk("sweep_rsp", addr, 16'h0203); cyc();
        addr_sel = 2'd3; #1 chk("sweep_alu", addr, 16'h1234); cyc();
        chk("sweep_pc_after", pc, 16'h0004);
        chk("sweep_dsp_after", dsp, 16'h0104);
        chk("sweep_rsp_after", rsp, 16'h0201);
        idle();

        // RSP underflow held while DSP reaches limit; push+clear keeps only new fault
        rsp_clken = 1; rsp_up = 0; cyc(); cyc(); idle();
        flags("rsp_unf2", 4'b0001);
        dsp_clken = 1; dsp_up = 1;
        repeat (251) cyc();
        chk("dsp_full2", dsp, 16'h01FF);
        fault_clr = 1; cyc(); idle();
        flags("ovf_clr_same", 4'b1000);

        // Reset dominates a simultaneous PC load
        reset = 1; pc_clken = 1; pc_load = 1; load_value = 16'hABCD;
        cyc(); idle();
        chk("rst_dom_pc", pc, 16'h0000);
        flags("rst_dom_flags", 4'b0000);

        // DSP underflow and RSP overflow
        dsp_clken = 1; dsp_up = 0; cyc(); idle();
        chk("dsp_unf_hold", dsp, 16'h0100);
        flags("dsp_unf", 4'b0100);
        rsp_clken = 1; rsp_up = 1;
        repeat (256) cyc(); idle();
        chk("rsp_ovf_hold", rsp, 16'h02FF);
        flags("rsp_ovf", 4'b0110);
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
